// File: rtl/addsub_seg_cla_if.sv
// Bus bundle for the segmented add/subtract unit: request operands in,
// handshake status and registered result/flags out.
interface addsub_seg_cla_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             select;
    logic             chain;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             c_out;
    logic             overflow;
    logic             negative;
    logic             zero;

    modport master (
        output start, select, chain, x, y,
        input  busy, done, z, c_out, overflow, negative, zero
    );

    modport slave (
        input  start, select, chain, x, y,
        output busy, done, z, c_out, overflow, negative, zero
    );
endinterface

// File: rtl/addsub_seg_cla.sv
// Multi-cycle add/subtract: one SEG-bit carry-lookahead segment per clock,
// LSB first, with registered N/Z/C/V flags and ADC/SBC-style chaining.
module addsub_seg_cla #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_seg_cla_if.slave  bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_chain;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_neg;
    logic             r_zero;

    logic [SEG-1:0]   w_sa;
    logic [SEG-1:0]   w_sb;
    logic [SEG-1:0]   w_g;
    logic [SEG-1:0]   w_p;
    logic [SEG:0]     w_c;
    logic [SEG-1:0]   w_s;
    logic [WIDTH-1:0] w_full;
    logic             w_last;

    assign w_sa = SEG'(r_a >> (r_idx * SEG));
    assign w_sb = SEG'(r_b >> (r_idx * SEG));

    genvar gi;
    generate
        for (gi = 0; gi < SEG; gi++) begin : g_gp
            assign w_g[gi] = w_sa[gi] & w_sb[gi];
            assign w_p[gi] = w_sa[gi] ^ w_sb[gi];
        end
    endgenerate

    // Each carry is expanded directly from the segment carry-in, so no bit
    // depends on the carry of its neighbour.
    always_comb begin
        w_c    = '0;
        w_c[0] = r_carry;
        for (int i = 1; i <= SEG; i++) begin
            w_c[i] = r_carry;
            for (int j = 0; j < i; j++) begin
                w_c[i] = w_g[j] | (w_p[j] & w_c[i]);
            end
        end
    end

    assign w_s    = w_p ^ w_c[SEG-1:0];
    assign w_full = r_sum | (WIDTH'(w_s) << (r_idx * SEG));
    assign w_last = (r_idx == IDXW'(NSEG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_chain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.x;
                        r_b     <= bus.y ^ {WIDTH{bus.select}};
                        r_carry <= bus.chain ? r_c_out : bus.select;
                        r_chain <= bus.chain;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_full;
                    r_carry <= w_c[SEG];
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_z     <= w_full;
                        r_c_out <= w_c[SEG];
                        // Carry into the MSB is the last internal carry of the top segment.
                        r_ovf   <= w_c[SEG] ^ w_c[SEG-1];
                        r_neg   <= w_full[WIDTH-1];
                        r_zero  <= (w_full == '0) & (~r_chain | r_zero);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.z        = r_z;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_ovf;
    assign bus.negative = r_neg;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_addsub_seg_cla.sv
// Self-checking bench for addsub_seg_cla: directed cases, handshake and reset
// scenarios, then random operations against an arithmetic reference model.
module tb_addsub_seg_cla;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Model state: the stored carry and zero flags as the spec defines them.
    logic m_c = 1'b0;
    logic m_z = 1'b0;

    addsub_seg_cla_if #(.WIDTH(16)) bus ();

    addsub_seg_cla #(.WIDTH(16), .SEG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sel,
                         input logic ch, output logic [15:0] ez, output logic ec,
                         output logic ev, output logic en, output logic ezr);
        logic [15:0] bb;
        logic        cin;
        logic [16:0] s;
        int          sv;
        bb  = sel ? ~b : b;
        cin = ch ? m_c : sel;
        s   = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
        sv  = $signed(a) + $signed(bb) + int'(cin);
        ez  = s[15:0];
        ec  = s[16];
        ev  = (sv > 32767) || (sv < -32768);
        en  = ez[15];
        ezr = (ez == 16'd0) && (!ch || m_z);
    endtask

    task automatic check_result(input string tag, input logic [15:0] ez, input logic ec,
                                input logic ev, input logic en, input logic ezr);
        check({tag, "_z"}, 32'(bus.z), 32'(ez));
        check({tag, "_flags"}, {28'd0, bus.c_out, bus.overflow, bus.negative, bus.zero},
              {28'd0, ec, ev, en, ezr});
        $display("op %s z=%h c=%0d v=%0d n=%0d zf=%0d", tag, bus.z, bus.c_out,
                 bus.overflow, bus.negative, bus.zero);
    endtask

    task automatic scramble_inputs();
        bus.x      = 16'($urandom);
        bus.y      = 16'($urandom);
        bus.select = 1'($urandom);
        bus.chain  = 1'($urandom);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sel, input logic ch);
        logic [15:0] ez;
        logic ec, ev, en, ezr;
        model(a, b, sel, ch, ez, ec, ev, en, ezr);
        @(negedge clk);
        bus.start = 1'b1; bus.x = a; bus.y = b; bus.select = sel; bus.chain = ch;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_bd_pre"}, {30'd0, bus.busy, bus.done}, 32'b10);
            @(posedge clk); #1;
        end
        check({tag, "_bd_done"}, {30'd0, bus.busy, bus.done}, 32'b01);
        check_result(tag, ez, ec, ev, en, ezr);
        m_c = ec; m_z = ezr;
        @(posedge clk); #1;
        check({tag, "_done_drop"}, {30'd0, bus.busy, bus.done}, 32'b00);
        check({tag, "_z_hold"}, 32'(bus.z), 32'(ez));
    endtask

    initial begin
        logic [15:0] ez;
        logic ec, ev, en, ezr;
        int   dones;

        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.select = 1'b0; bus.chain = 1'b0;
        #1;
        check("reset_state", {12'd0, bus.z, bus.busy, bus.done, bus.c_out, bus.overflow,
                              bus.negative, bus.zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("add1",   16'h1234, 16'h0FCD, 1'b0, 1'b0);
        do_op("add_ov", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op("add_ff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        do_op("sub_eq", 16'h0064, 16'h0064, 1'b1, 1'b0);
        do_op("sub_ng", 16'h001E, 16'h0032, 1'b1, 1'b0);
        do_op("sub_ov", 16'h8000, 16'h0001, 1'b1, 1'b0);
        do_op("ch_a0",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op("ch_a1",  16'h0000, 16'h0000, 1'b0, 1'b1);
        do_op("ch_s0",  16'h0000, 16'h0001, 1'b1, 1'b0);
        do_op("ch_s1",  16'h0001, 16'h0000, 1'b1, 1'b1);

        // Starts pulsed during RUN must be ignored.
        model(16'h1111, 16'h2222, 1'b0, 1'b0, ez, ec, ev, en, ezr);
        @(negedge clk);
        bus.start = 1'b1; bus.x = 16'h1111; bus.y = 16'h2222; bus.select = 1'b0; bus.chain = 1'b0;
        @(posedge clk); #1;
        bus.x = 16'hAAAA; bus.y = 16'h5555; bus.select = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk); #1;
        check("ign_done", {30'd0, bus.busy, bus.done}, 32'b01);
        check_result("ign", ez, ec, ev, en, ezr);
        m_c = ec; m_z = ezr;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            dones += int'(bus.done) + int'(bus.busy);
        end
        check("ign_single_done", 32'(dones), 32'd0);

        // Start held high through done: next op accepted on the done cycle.
        model(16'h0F0F, 16'h00F1, 1'b0, 1'b0, ez, ec, ev, en, ezr);
        @(negedge clk);
        bus.start = 1'b1; bus.x = 16'h0F0F; bus.y = 16'h00F1; bus.select = 1'b0; bus.chain = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_done1", {30'd0, bus.busy, bus.done}, 32'b01);
        check_result("b2b1", ez, ec, ev, en, ezr);
        m_c = ec; m_z = ezr;
        model(16'h4000, 16'h4000, 1'b1, 1'b1, ez, ec, ev, en, ezr);
        bus.x = 16'h4000; bus.y = 16'h4000; bus.select = 1'b1; bus.chain = 1'b1;
        @(posedge clk); #1;
        check("b2b_accept", {30'd0, bus.busy, bus.done}, 32'b10);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("b2b_busy", {30'd0, bus.busy, bus.done}, 32'b10);
        @(posedge clk); #1;
        check("b2b_done2", {30'd0, bus.busy, bus.done}, 32'b01);
        check_result("b2b2", ez, ec, ev, en, ezr);
        m_c = ec; m_z = ezr;

        // Asynchronous reset mid-RUN after leaving nonzero flags behind.
        do_op("pre_rst", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.x = 16'hFFFF; bus.y = 16'hFFFF; bus.select = 1'b0; bus.chain = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid", {12'd0, bus.z, bus.busy, bus.done, bus.c_out, bus.overflow,
                          bus.negative, bus.zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_c = 1'b0; m_z = 1'b0;
        dones = 0;
        repeat (6) begin
            @(posedge clk); #1;
            dones += int'(bus.done) + int'(bus.busy);
        end
        check("rst_no_done", 32'(dones), 32'd0);
        do_op("rst_chain", 16'h0001, 16'h0001, 1'b0, 1'b1);
        check("rst_chain_val", 32'(bus.z), 32'h0002);

        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
